transpad_cfg_tx: RTL and testbench

Host-side command transmitter for the transpad snooping unit. It accepts one transpad configuration descriptor over a valid/ready handshake and serializes it onto the transpad command bus (`cmd`, `data`, `rdy`): five register-write beats, then the start beat. It holds the session active until a stop request, then emits the stop beat. It sits between the host control logic and the transpad command inputs, and is the transmitting end of the interface the transpad datapath decodes.

---
 rtl/transpad_pkg.sv | 53 +++++
 rtl/transpad_cfg_tx_register.sv | 26 ++
 rtl/transpad_cfg_tx.sv | 171 +++++++++++++++++
 tb/tb_transpad_cfg_tx.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/transpad_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : transpad_pkg                                                 |
// | Description : Shared command codes, keys and FSM states for the transpad   |
// |               command bus transmitter.                                     |
// | Revision    : 1.0                                                          |
// +----------------------------------------------------------------------------+
package transpad_pkg;

    localparam logic [2:0] CMD_ST_ADDR = 3'd0;
    localparam logic [2:0] CMD_SD2     = 3'd1;
    localparam logic [2:0] CMD_D3      = 3'd2;
    localparam logic [2:0] CMD_OLP     = 3'd3;
    localparam logic [2:0] CMD_MOD     = 3'd4;
    localparam logic [2:0] CMD_CTRL    = 3'd7;

    localparam logic [7:0] START_KEY = 8'hA5;
    localparam logic [7:0] STOP_KEY  = 8'h5A;

    localparam logic [3:0] MODE_C = 4'hC;
    localparam logic [3:0] MODE_D = 4'hD;
    localparam logic [3:0] MODE_E = 4'hE;

    // Slot indices of the 16-bit descriptor fields in the capture array
    localparam int c_fld_str1   = 0;
    localparam int c_fld_str2   = 1;
    localparam int c_fld_str3   = 2;
    localparam int c_fld_ofs2   = 3;
    localparam int c_fld_ofs3   = 4;
    localparam int c_fld_oofs   = 5;
    localparam int c_fld_olen   = 6;
    localparam int c_fld_len    = 7;
    localparam int c_fld_mode   = 8;
    localparam int c_num_fields = 9;

    typedef enum logic [3:0] {
        IDLE   = 4'd0,
        W_ST   = 4'd1,
        W_SD2  = 4'd2,
        W_D3   = 4'd3,
        W_OLP  = 4'd4,
        W_MOD  = 4'd5,
        START  = 4'd6,
        ACTIVE = 4'd7,
        STOP   = 4'd8
    } tx_state_e;

    function automatic logic mode_is_valid(input logic [3:0] mode_nib);
        return (mode_nib == MODE_C) || (mode_nib == MODE_D) || (mode_nib == MODE_E);
    endfunction

endpackage
`default_nettype wire

// File: rtl/transpad_cfg_tx_register.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : register                                                     |
// | Description : Write-enabled storage register with async active-low clear.  |
// | Revision    : 1.0                                                          |
// +----------------------------------------------------------------------------+
module register #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             we,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            q <= '0;
        end else if (we) begin
            q <= d;
        end
    end

endmodule
`default_nettype wire

// File: rtl/transpad_cfg_tx.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : transpad_cfg_tx                                              |
// | Description : Serializes one transpad configuration descriptor onto the    |
// |               command bus, holds the session, then sends the stop beat.    |
// | Revision    : 1.0                                                          |
// +----------------------------------------------------------------------------+
module transpad_cfg_tx
    import transpad_pkg::*;
(
    input  logic        clk,
    input  logic        rstn,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [47:0] req_st_addr,
    input  logic [15:0] req_str1,
    input  logic [15:0] req_str2,
    input  logic [15:0] req_str3,
    input  logic [15:0] req_ofs2,
    input  logic [15:0] req_ofs3,
    input  logic [15:0] req_oofs,
    input  logic [15:0] req_olen,
    input  logic [15:0] req_len,
    input  logic [15:0] req_mode,
    input  logic        stop,
    input  logic        gnt,
    output logic [2:0]  cmd,
    output logic [47:0] data,
    output logic        rdy,
    output logic        active,
    output logic        err
);

    tx_state_e   r_state;
    logic        w_accept;
    logic [47:0] r_desc_st_addr;
    logic [15:0] w_field_d    [c_num_fields];
    logic [15:0] r_desc_field [c_num_fields];

    assign req_ready = (r_state == IDLE);
    assign w_accept  = req_valid && req_ready;

    assign w_field_d[c_fld_str1] = req_str1;
    assign w_field_d[c_fld_str2] = req_str2;
    assign w_field_d[c_fld_str3] = req_str3;
    assign w_field_d[c_fld_ofs2] = req_ofs2;
    assign w_field_d[c_fld_ofs3] = req_ofs3;
    assign w_field_d[c_fld_oofs] = req_oofs;
    assign w_field_d[c_fld_olen] = req_olen;
    assign w_field_d[c_fld_len]  = req_len;
    assign w_field_d[c_fld_mode] = req_mode;

    register #(.WIDTH(48)) u_st_addr (
        .clk  (clk),
        .rstn (rstn),
        .we   (w_accept),
        .d    (req_st_addr),
        .q    (r_desc_st_addr)
    );

    generate
        for (genvar gi = 0; gi < c_num_fields; gi++) begin : g_field
            register #(.WIDTH(16)) u_field (
                .clk  (clk),
                .rstn (rstn),
                .we   (w_accept),
                .d    (w_field_d[gi]),
                .q    (r_desc_field[gi])
            );
        end
    endgenerate

    // Bus outputs default to zero every edge so only beat cycles carry payload
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state <= IDLE;
            cmd     <= CMD_ST_ADDR;
            data    <= '0;
            rdy     <= 1'b0;
            active  <= 1'b0;
            err     <= 1'b0;
        end else begin
            cmd  <= CMD_ST_ADDR;
            data <= '0;
            rdy  <= 1'b0;
            err  <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        r_state <= W_ST;
                    end
                end
                W_ST: begin
                    if (gnt) begin
                        cmd     <= CMD_ST_ADDR;
                        data    <= r_desc_st_addr;
                        rdy     <= 1'b1;
                        r_state <= W_SD2;
                    end
                end
                W_SD2: begin
                    if (gnt) begin
                        cmd     <= CMD_SD2;
                        data    <= {r_desc_field[c_fld_str1], r_desc_field[c_fld_str2],
                                    r_desc_field[c_fld_ofs2]};
                        rdy     <= 1'b1;
                        r_state <= W_D3;
                    end
                end
                W_D3: begin
                    if (gnt) begin
                        cmd     <= CMD_D3;
                        data    <= {16'h0, r_desc_field[c_fld_str3], r_desc_field[c_fld_ofs3]};
                        rdy     <= 1'b1;
                        r_state <= W_OLP;
                    end
                end
                W_OLP: begin
                    if (gnt) begin
                        cmd     <= CMD_OLP;
                        data    <= {16'h0, r_desc_field[c_fld_oofs], r_desc_field[c_fld_olen]};
                        rdy     <= 1'b1;
                        r_state <= W_MOD;
                    end
                end
                W_MOD: begin
                    if (gnt) begin
                        cmd  <= CMD_MOD;
                        data <= {16'h0, r_desc_field[c_fld_mode], r_desc_field[c_fld_len]};
                        rdy  <= 1'b1;
                        // The mode beat has already gone out; only the start is withheld
                        if (mode_is_valid(r_desc_field[c_fld_mode][3:0])) begin
                            r_state <= START;
                        end else begin
                            err     <= 1'b1;
                            r_state <= IDLE;
                        end
                    end
                end
                START: begin
                    if (gnt) begin
                        cmd     <= CMD_CTRL;
                        data    <= {40'h0, START_KEY};
                        rdy     <= 1'b1;
                        active  <= 1'b1;
                        r_state <= ACTIVE;
                    end
                end
                ACTIVE: begin
                    if (stop) begin
                        r_state <= STOP;
                    end
                end
                STOP: begin
                    if (gnt) begin
                        cmd     <= CMD_CTRL;
                        data    <= {40'h0, STOP_KEY};
                        rdy     <= 1'b1;
                        active  <= 1'b0;
                        r_state <= IDLE;
                    end
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_transpad_cfg_tx.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_transpad_cfg_tx                                           |
// | Description : Table-driven self-checking bench for transpad_cfg_tx.        |
// | Revision    : 1.0                                                          |
// +----------------------------------------------------------------------------+
module tb_transpad_cfg_tx;

    logic        clk;
    logic        rstn;
    logic        req_valid;
    logic        req_ready;
    logic [47:0] req_st_addr;
    logic [15:0] req_str1, req_str2, req_str3, req_ofs2, req_ofs3;
    logic [15:0] req_oofs, req_olen, req_len, req_mode;
    logic        stop;
    logic        gnt;
    logic [2:0]  cmd;
    logic [47:0] data;
    logic        rdy;
    logic        active;
    logic        err;

    int n_checks = 0;
    int n_errors = 0;

    typedef struct packed {
        logic [47:0]      st_addr;
        logic [15:0]      str1, str2, str3, ofs2, ofs3, oofs, olen, len, mode;
        logic             stall;
        logic [2:0]       nbeats;
        logic             exp_err;
        logic             exp_active;
        logic [5:0][2:0]  exp_cmd;
        logic [5:0][47:0] exp_data;
    } vec_t;

    vec_t vecs [5];

    transpad_cfg_tx dut (
        .clk         (clk),
        .rstn        (rstn),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_st_addr (req_st_addr),
        .req_str1    (req_str1),
        .req_str2    (req_str2),
        .req_str3    (req_str3),
        .req_ofs2    (req_ofs2),
        .req_ofs3    (req_ofs3),
        .req_oofs    (req_oofs),
        .req_olen    (req_olen),
        .req_len     (req_len),
        .req_mode    (req_mode),
        .stop        (stop),
        .gnt         (gnt),
        .cmd         (cmd),
        .data        (data),
        .rdy         (rdy),
        .active      (active),
        .err         (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL global_timeout");
        $fatal(1, "simulation time limit exceeded");
    end

    task automatic check_v(input string name, input logic [47:0] act, input logic [47:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic load_desc(input vec_t v);
        req_st_addr = v.st_addr;
        req_str1 = v.str1;  req_str2 = v.str2;  req_str3 = v.str3;
        req_ofs2 = v.ofs2;  req_ofs3 = v.ofs3;  req_oofs = v.oofs;
        req_olen = v.olen;  req_len  = v.len;   req_mode = v.mode;
    endtask

    // Offers one descriptor, follows its beats under the chosen grant pattern,
    // then closes the session with a stop beat when one was started.
    task automatic run_vec(input int idx, input int stop_cyc);
        vec_t v;
        int   beat;
        int   cyc;
        logic g;
        v = vecs[idx];
        check_v("req_ready_idle", 48'(req_ready), 48'd1);
        load_desc(v);
        req_valid = 1'b1;
        gnt = 1'b0;
        @(posedge clk); #1;
        req_valid = 1'b0;
        check_v("req_ready_busy", 48'(req_ready), 48'd0);
        beat = 0;
        cyc = 0;
        while (beat < int'(v.nbeats) && cyc < 60) begin
            g = v.stall ? (cyc % 3 == 0) : 1'b1;
            gnt = g;
            stop = (cyc == stop_cyc);
            @(posedge clk); #1;
            stop = 1'b0;
            check_v("rdy_follows_gnt", 48'(rdy), 48'(g));
            if (rdy) begin
                check_v("beat_cmd", 48'(cmd), 48'(v.exp_cmd[beat]));
                check_v("beat_data", data, v.exp_data[beat]);
                if (beat == 4) begin
                    check_v("err_after_mod", 48'(err), 48'(v.exp_err));
                    check_v("ready_after_mod", 48'(req_ready), 48'(v.exp_err));
                end
                check_v("active_with_start", 48'(active), 48'(beat == 5));
                beat++;
            end
            cyc++;
        end
        if (beat < int'(v.nbeats)) begin
            n_checks++;
            n_errors++;
            $display("FAIL beat_timeout: got %0d beats expected %0d", beat, v.nbeats);
        end
        gnt = 1'b1;
        @(posedge clk); #1;
        check_v("no_extra_beat", 48'(rdy), 48'd0);
        check_v("err_one_cycle", 48'(err), 48'd0);
        check_v("active_after_cfg", 48'(active), 48'(v.exp_active));
        check_v("ready_after_cfg", 48'(req_ready), 48'(!v.exp_active));
        if (v.exp_active) begin
            stop = 1'b1;
            gnt = 1'b0;
            @(posedge clk); #1;
            stop = 1'b0;
            check_v("stop_sample_no_beat", 48'(rdy), 48'd0);
            check_v("active_until_stop_beat", 48'(active), 48'd1);
            gnt = 1'b1;
            @(posedge clk); #1;
            check_v("stop_rdy", 48'(rdy), 48'd1);
            check_v("stop_cmd", 48'(cmd), 48'd7);
            check_v("stop_data", data, 48'h0000_0000_005A);
            check_v("stop_active", 48'(active), 48'd0);
            check_v("stop_ready", 48'(req_ready), 48'd1);
        end
        gnt = 1'b0;
    endtask

    initial begin
        vecs[0] = '0;
        vecs[0].st_addr = 48'h0000_1000_0000;
        vecs[0].str1 = 16'h0010; vecs[0].str2 = 16'h0020; vecs[0].str3 = 16'h0030;
        vecs[0].ofs2 = 16'h0002; vecs[0].ofs3 = 16'h0003; vecs[0].oofs = 16'h0040;
        vecs[0].olen = 16'h0008; vecs[0].len  = 16'h0004; vecs[0].mode = 16'h000C;
        vecs[0].stall = 1'b0; vecs[0].nbeats = 3'd6; vecs[0].exp_err = 1'b0; vecs[0].exp_active = 1'b1;
        vecs[0].exp_cmd  = {3'd7, 3'd4, 3'd3, 3'd2, 3'd1, 3'd0};
        vecs[0].exp_data = {48'h0000_0000_00A5, 48'h0000_000C_0004, 48'h0000_0040_0008,
                            48'h0000_0030_0003, 48'h0010_0020_0002, 48'h0000_1000_0000};

        vecs[1] = vecs[0];
        vecs[1].mode = 16'h0005;
        vecs[1].nbeats = 3'd5; vecs[1].exp_err = 1'b1; vecs[1].exp_active = 1'b0;
        vecs[1].exp_cmd  = {3'd0, 3'd4, 3'd3, 3'd2, 3'd1, 3'd0};
        vecs[1].exp_data = {48'h0, 48'h0000_0005_0004, 48'h0000_0040_0008,
                            48'h0000_0030_0003, 48'h0010_0020_0002, 48'h0000_1000_0000};

        vecs[2] = '0;
        vecs[2].st_addr = 48'hFFFF_FFFF_FFFF;
        vecs[2].str1 = 16'hFFFF; vecs[2].str2 = 16'h1234; vecs[2].str3 = 16'h5678;
        vecs[2].ofs2 = 16'hABCD; vecs[2].ofs3 = 16'h9ABC; vecs[2].oofs = 16'hDEAD;
        vecs[2].olen = 16'hBEEF; vecs[2].len  = 16'h0001; vecs[2].mode = 16'hF00E;
        vecs[2].stall = 1'b1; vecs[2].nbeats = 3'd6; vecs[2].exp_err = 1'b0; vecs[2].exp_active = 1'b1;
        vecs[2].exp_cmd  = {3'd7, 3'd4, 3'd3, 3'd2, 3'd1, 3'd0};
        vecs[2].exp_data = {48'h0000_0000_00A5, 48'h0000_F00E_0001, 48'h0000_DEAD_BEEF,
                            48'h0000_5678_9ABC, 48'hFFFF_1234_ABCD, 48'hFFFF_FFFF_FFFF};

        vecs[3] = '0;
        vecs[3].ofs3 = 16'h0001; vecs[3].mode = 16'h000F;
        vecs[3].stall = 1'b0; vecs[3].nbeats = 3'd5; vecs[3].exp_err = 1'b1; vecs[3].exp_active = 1'b0;
        vecs[3].exp_cmd  = {3'd0, 3'd4, 3'd3, 3'd2, 3'd1, 3'd0};
        vecs[3].exp_data = {48'h0, 48'h0000_000F_0000, 48'h0, 48'h0000_0000_0001, 48'h0, 48'h0};

        vecs[4] = vecs[0];
        vecs[4].mode = 16'h000D;
        vecs[4].exp_data[4] = 48'h0000_000D_0004;

        rstn = 1'b0;
        req_valid = 1'b0;
        stop = 1'b0;
        gnt = 1'b0;
        load_desc(vecs[0]);
        @(posedge clk); @(posedge clk); #1;
        check_v("reset_cmd", 48'(cmd), 48'd0);
        check_v("reset_data", data, 48'd0);
        check_v("reset_rdy", 48'(rdy), 48'd0);
        check_v("reset_active", 48'(active), 48'd0);
        check_v("reset_err", 48'(err), 48'd0);
        check_v("reset_ready", 48'(req_ready), 48'd1);
        rstn = 1'b1;
        @(posedge clk); #1;

        for (int i = 0; i < 5; i++) begin
            run_vec(i, -1);
        end

        // Stop pulse while the second beat is pending must be ignored
        run_vec(0, 1);

        // Asynchronous reset while the W_D3 beat is pending
        load_desc(vecs[0]);
        req_valid = 1'b1;
        @(posedge clk); #1;
        req_valid = 1'b0;
        gnt = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        check_v("pre_reset_cmd", 48'(cmd), 48'd1);
        rstn = 1'b0;
        #1;
        check_v("async_rst_rdy", 48'(rdy), 48'd0);
        check_v("async_rst_cmd", 48'(cmd), 48'd0);
        check_v("async_rst_data", data, 48'd0);
        check_v("async_rst_ready", 48'(req_ready), 48'd1);
        @(posedge clk); #1;
        rstn = 1'b1;
        gnt = 1'b0;
        @(posedge clk); #1;
        run_vec(1, -1);
        run_vec(0, -1);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
